// File: rtl/ws2811_pkg.sv
// ws2811_pkg: WS2811 timing defaults and word width shared by TX and RX.
package ws2811_pkg;
  localparam int BIT_THRESHOLD = 25;
  localparam int MIN_HIGH      = 5;
  localparam int MAX_HIGH      = 60;
  localparam int RESET_CYCLES  = 2500;
  localparam int MAX_LEDS      = 255;
  localparam int WORD_W        = 24;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ws2811_pulse_meter.sv
// ws2811_pulse_meter: synchronises the line and measures high-pulse widths and low gaps.
module ws2811_pulse_meter
  import ws2811_pkg::*;
#(
  parameter int P_MIN_HIGH     = MIN_HIGH,
  parameter int P_MAX_HIGH     = MAX_HIGH,
  parameter int P_RESET_CYCLES = RESET_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_serial,
  input  logic i_in_frame,
  output logic o_sync,
  output logic o_rise,
  output logic o_pulse_done,
  output logic o_glitch,
  output logic [$clog2(P_MAX_HIGH+2)-1:0] o_pulse_width,
  output logic o_over,
  output logic o_gap_seen
);
  localparam int HW = $clog2(P_MAX_HIGH + 2);
  localparam int LW = $clog2(P_RESET_CYCLES + 1);
  logic [1:0] r_sync;
  logic r_prev;
  logic [HW-1:0] r_high_cnt;
  logic [LW-1:0] r_low_cnt;
  logic w_line, w_rise, w_fall, w_short;
  assign w_line  = r_sync[1];
  assign w_rise  = w_line & ~r_prev;
  assign w_fall  = ~w_line & r_prev;
  assign w_short = r_high_cnt < HW'(P_MIN_HIGH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_high_cnt <= '0;
      r_low_cnt  <= '0;
    end else begin
      r_sync     <= {r_sync[0], i_serial};
      r_prev     <= w_line;
      r_high_cnt <= w_rise ? HW'(1) :
                    (w_line && r_high_cnt <= HW'(P_MAX_HIGH)) ? r_high_cnt + HW'(1) : r_high_cnt;
      // inside a frame a high (or a dropped glitch) freezes the gap count instead of clearing it
      r_low_cnt  <= w_line ? (i_in_frame ? r_low_cnt : '0) :
                    w_fall ? (w_short ? r_low_cnt : LW'(1)) :
                    (r_low_cnt < LW'(P_RESET_CYCLES)) ? r_low_cnt + LW'(1) : r_low_cnt;
    end
  assign o_sync        = w_line;
  assign o_rise        = w_rise;
  assign o_pulse_done  = w_fall & ~w_short;
  assign o_glitch      = w_fall & w_short;
  assign o_pulse_width = r_high_cnt;
  assign o_over        = w_line & (r_high_cnt > HW'(P_MAX_HIGH));
  assign o_gap_seen    = ~w_line & (r_low_cnt == LW'(P_RESET_CYCLES));
endmodule

// File: rtl/ws2811_serial_decoder.sv
// ws2811_serial_decoder: decodes a WS2811 line into 24-bit LED words and frame-latch events.
module ws2811_serial_decoder
  import ws2811_pkg::*;
#(
  parameter int P_BIT_THRESHOLD = BIT_THRESHOLD,
  parameter int P_MIN_HIGH      = MIN_HIGH,
  parameter int P_MAX_HIGH      = MAX_HIGH,
  parameter int P_RESET_CYCLES  = RESET_CYCLES,
  parameter int P_MAX_LEDS      = MAX_LEDS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_serial,
  output logic [WORD_W-1:0] o_word,
  output logic [$clog2(P_MAX_LEDS+1)-1:0] o_word_index,
  output logic o_word_valid,
  output logic o_frame_done,
  output logic [$clog2(P_MAX_LEDS+1)-1:0] o_frame_leds,
  output logic o_frame_partial,
  output logic o_error,
  output logic o_db_serial
);
  localparam logic [1:0] S_WAIT_GAP = 2'd0, S_IDLE = 2'd1, S_HIGH = 2'd2, S_LOW = 2'd3;
  localparam int HW = $clog2(P_MAX_HIGH + 2);
  localparam int CW = $clog2(P_MAX_LEDS + 1);
  localparam int BW = $clog2(WORD_W + 1);
  logic [1:0] r_state, w_state_nxt;
  word_t r_sreg, r_word;
  logic [BW-1:0] r_bit_cnt;
  logic [CW-1:0] r_led_cnt, r_word_index, r_frame_leds;
  logic r_word_valid, r_frame_done, r_frame_partial, r_error;
  logic w_sync, w_rise, w_pulse_done, w_glitch, w_over, w_gap;
  logic [HW-1:0] w_width;
  logic w_in_frame, w_gap_end, w_frame_fire, w_clear, w_shift, w_word_out, w_long, w_ovf;
  ws2811_pulse_meter #(
    .P_MIN_HIGH(P_MIN_HIGH),
    .P_MAX_HIGH(P_MAX_HIGH),
    .P_RESET_CYCLES(P_RESET_CYCLES)
  ) u_meter (
    .clk(clk),
    .rst_n(rst_n),
    .i_serial(i_serial),
    .i_in_frame(w_in_frame),
    .o_sync(w_sync),
    .o_rise(w_rise),
    .o_pulse_done(w_pulse_done),
    .o_glitch(w_glitch),
    .o_pulse_width(w_width),
    .o_over(w_over),
    .o_gap_seen(w_gap)
  );
  assign w_in_frame = (r_state == S_HIGH) || (r_state == S_LOW);
  always_comb
    w_state_nxt = !i_enable              ? S_WAIT_GAP :
                  (r_state == S_WAIT_GAP) ? (w_gap ? S_IDLE : S_WAIT_GAP) :
                  (r_state == S_IDLE)     ? (w_rise ? S_HIGH : S_IDLE) :
                  (r_state == S_HIGH)     ? (w_over ? S_WAIT_GAP : (w_pulse_done || w_glitch) ? S_LOW : S_HIGH) :
                  (w_gap ? S_IDLE : w_rise ? S_HIGH : S_LOW);
  assign w_gap_end    = i_enable && (r_state == S_LOW) && w_gap;
  assign w_frame_fire = w_gap_end && (r_led_cnt != '0 || r_bit_cnt != '0);
  assign w_clear      = (w_state_nxt == S_WAIT_GAP) || w_gap_end;
  assign w_shift      = !w_clear && (r_state == S_HIGH) && w_pulse_done;
  assign w_word_out   = !w_clear && (r_bit_cnt == BW'(WORD_W));
  assign w_long       = i_enable && (r_state == S_HIGH) && w_over;
  assign w_ovf        = w_word_out && (r_led_cnt == CW'(P_MAX_LEDS));
  // UC half: bit shifting and word assembly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_led_cnt    <= '0;
      r_word       <= '0;
      r_word_index <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= w_word_out;
      if (w_clear) begin
        r_bit_cnt <= '0;
        r_led_cnt <= '0;
      end else if (w_shift) begin
        r_sreg    <= {r_sreg[WORD_W-2:0], w_width >= HW'(P_BIT_THRESHOLD)};
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end else if (w_word_out) begin
        r_word       <= r_sreg;
        r_word_index <= r_led_cnt;
        r_led_cnt    <= (r_led_cnt == CW'(P_MAX_LEDS)) ? r_led_cnt : r_led_cnt + CW'(1);
        r_bit_cnt    <= '0;
      end
    end
  // FD half: state, latch-gap reporting and sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state         <= S_WAIT_GAP;
      r_frame_done    <= 1'b0;
      r_frame_leds    <= '0;
      r_frame_partial <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame_fire;
      r_error      <= w_frame_fire ? 1'b0 : (r_error || w_long || w_ovf);
      if (w_frame_fire) begin
        r_frame_leds    <= r_led_cnt;
        r_frame_partial <= r_bit_cnt != '0;
      end
    end
  assign o_word          = r_word;
  assign o_word_index    = r_word_index;
  assign o_word_valid    = r_word_valid;
  assign o_frame_done    = r_frame_done;
  assign o_frame_leds    = r_frame_leds;
  assign o_frame_partial = r_frame_partial;
  assign o_error         = r_error;
  assign o_db_serial     = w_sync;
endmodule
